// File: rtl/iter_shift_unit.sv
// Iterative SLL/SRL/SRA/ROR unit: one binary-weighted shift stage per clock, start/ready handshake.
// Optional macro SHIFT_EARLY_DONE_EN ends the operation once no higher shift-amount bits remain.
module iter_shift_unit #(
  parameter int  DATA_WIDTH  = 32,
  localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ctrl_start,
  input  logic [1:0]             ctrl_shiftop,
  input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
  input  logic [DATA_WIDTH-1:0]  data_operandA,
  output logic [DATA_WIDTH-1:0]  data_result,
  output logic                   data_resultRDY,
  output logic                   ctrl_busy
);

  localparam int CNT_WIDTH = $clog2(SHAMT_WIDTH);
  localparam logic [CNT_WIDTH-1:0]   LAST_STAGE = CNT_WIDTH'(SHAMT_WIDTH - 1);
  localparam logic [SHAMT_WIDTH:0]   DW_EXT     = (SHAMT_WIDTH + 1)'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} shift_op_e;

  state_e                  state_q, state_d;
  shift_op_e               op_q, op_d;
  logic [SHAMT_WIDTH-1:0]  amt_q, amt_d;
  logic [CNT_WIDTH-1:0]    k_q, k_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    sign_q, sign_d;

  logic                    accept;
  logic                    lastStage;
  logic [SHAMT_WIDTH-1:0]  stepAmt;
  logic [SHAMT_WIDTH:0]    revAmt;
  logic [DATA_WIDTH-1:0]   onesShr;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   stageVal;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      amt_q    <= '0;
      k_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      amt_q    <= amt_d;
      k_q      <= k_d;
      work_q   <= work_d;
      result_q <= result_d;
      sign_q   <= sign_d;
    end
  end

  // Stage k moves the work register by 2^k; SRA fills from the sign captured at accept.
  always_comb begin
    stepAmt = SHAMT_WIDTH'(1) << k_q;
    revAmt  = DW_EXT - {1'b0, stepAmt};
    onesShr = {DATA_WIDTH{1'b1}} >> stepAmt;
    shifted = work_q;
    case (op_q)
      OP_SLL:  shifted = work_q << stepAmt;
      OP_SRL:  shifted = work_q >> stepAmt;
      OP_SRA:  shifted = (work_q >> stepAmt) | (sign_q ? ~onesShr : '0);
      OP_ROR:  shifted = (work_q >> stepAmt) | (work_q << revAmt);
      default: shifted = work_q;
    endcase
    stageVal = amt_q[k_q] ? shifted : work_q;
`ifdef SHIFT_EARLY_DONE_EN
    lastStage = (k_q == LAST_STAGE) || (((amt_q >> k_q) >> 1) == '0);
`else
    lastStage = (k_q == LAST_STAGE);
`endif
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    amt_d    = amt_q;
    k_d      = k_q;
    work_d   = work_q;
    result_d = result_q;
    sign_d   = sign_q;
    accept   = ctrl_start && (state_q == IDLE || state_q == DONE);
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          op_d    = shift_op_e'(ctrl_shiftop);
          amt_d   = ctrl_shiftamt;
          work_d  = data_operandA;
          sign_d  = data_operandA[DATA_WIDTH-1];
          k_d     = '0;
          state_d = SHIFT;
`ifdef SHIFT_EARLY_DONE_EN
          if (ctrl_shiftamt == '0) begin
            state_d  = DONE;
            result_d = data_operandA;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stageVal;
        if (lastStage) begin
          state_d  = DONE;
          result_d = stageVal;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_result    = result_q;
    data_resultRDY = (state_q == DONE);
    ctrl_busy      = (state_q == SHIFT);
  end

endmodule
